cp_ingress_parser: RTL and testbench

CP_INGRESS_PARSER -- requirements
Module: cp_ingress_parser

---
 rtl/cp_ingress_parser.sv | 225 ++++++++++++++++++++++
 tb/tb_cp_ingress_parser.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_ingress_parser.sv
// rtl/cp_ingress_parser.sv - ingress packet parser: header decode, config-table load, stream pass-through
//
// Purpose:
//   Parses one packet per pass. The first accepted beat is a header carrying three
//   entry counts (and an opcode in the top byte). After a two-cycle gap the parser
//   forwards exactly num_entry_state + num_pe_tables*num_entry_config_table +
//   num_entry_inbound load beats to the control plane on wr_data/wr_valid. The rest of
//   the packet is then passed through on stream_data/stream_valid, under
//   ready_stream_in backpressure, until s_tlast.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast ingress beat, valid, end of packet
//   s_tready                 ingress accept
//   start_loader             one-cycle pulse after a header is accepted
//   num_entry_*              count fields latched from the header
//   wr_data/wr_valid         registered load beat to the control plane
//   start_stream_in          high while in the stream phase
//   ready_stream_in          control-plane backpressure for stream beats
//   stream_data/stream_valid registered stream beat
//   err                      sticky {bad_opcode, short_pkt, underrun}
//
// Build option:
//   CP_HDR_OPCODE_CHECK_EN   when defined, headers whose opcode is not 8'hA5 are
//                            flagged as bad_opcode and the packet is drained.

module cp_ingress_parser #(
  parameter int phit_size     = 512,
  parameter int dwidth_RFadd  = 8,
  parameter int num_pe_tables = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [phit_size-1:0]    s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    start_loader,
  output logic [dwidth_RFadd-1:0] num_entry_state,
  output logic [dwidth_RFadd-1:0] num_entry_config_table,
  output logic [dwidth_RFadd-1:0] num_entry_inbound,
  output logic [phit_size-1:0]    wr_data,
  output logic                    wr_valid,
  output logic                    start_stream_in,
  input  logic                    ready_stream_in,
  output logic [phit_size-1:0]    stream_data,
  output logic                    stream_valid,
  output logic [2:0]              err
);

  // Four extra bits cover the worst-case sum of three count fields with the
  // config-table field multiplied by the table count.
  localparam int CW = dwidth_RFadd + 4;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR_GAP = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] STREAM  = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  logic [2:0]              r_state;
  logic [2:0]              w_next_state;
  logic                    r_ready;
  logic                    r_gap;
  logic                    r_hdr_last;
  logic [CW-1:0]           r_load_cnt;
  logic [CW-1:0]           w_total;
  logic                    w_load_last;
  logic [dwidth_RFadd-1:0] r_num_state;
  logic [dwidth_RFadd-1:0] r_num_cfg;
  logic [dwidth_RFadd-1:0] r_num_inb;
  logic                    r_start_loader;
  logic [phit_size-1:0]    r_wr_data;
  logic                    r_wr_valid;
  logic [phit_size-1:0]    r_stream_data;
  logic                    r_stream_valid;
  logic                    r_err_under;
  logic                    r_err_short;
  logic                    w_accept;
  logic                    w_hdr_ok;

`ifdef CP_HDR_OPCODE_CHECK_EN
  localparam logic [7:0] HDR_OPCODE = 8'hA5;
  logic r_err_opcode;
  assign w_hdr_ok = (s_tdata[phit_size-1 -: 8] == HDR_OPCODE);
  assign err      = {r_err_opcode, r_err_short, r_err_under};
`else
  assign w_hdr_ok = 1'b1;
  assign err      = {1'b0, r_err_short, r_err_under};
`endif

  // In the stream phase acceptance follows the control plane directly; elsewhere
  // it comes from a register so reset can hold it low on the same edge.
  assign s_tready = (r_state == STREAM) ? ready_stream_in : r_ready;
  assign w_accept = s_tvalid & s_tready;

  assign w_total     = CW'(r_num_state) + CW'(num_pe_tables) * CW'(r_num_cfg) + CW'(r_num_inb);
  assign w_load_last = (r_load_cnt == w_total - CW'(1));

  assign start_loader           = r_start_loader;
  assign num_entry_state        = r_num_state;
  assign num_entry_config_table = r_num_cfg;
  assign num_entry_inbound      = r_num_inb;
  assign wr_data                = r_wr_data;
  assign wr_valid               = r_wr_valid;
  assign start_stream_in        = (r_state == STREAM);
  assign stream_data            = r_stream_data;
  assign stream_valid           = r_stream_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_hdr_ok) begin
            w_next_state = s_tlast ? IDLE : DRAIN;
          end else begin
            w_next_state = HDR_GAP;
          end
        end
      end
      HDR_GAP: begin
        // A header that was also the last beat still goes through the gap so the
        // control plane sees a normal start_loader, then nothing follows.
        if (r_gap) begin
          if (r_hdr_last) begin
            w_next_state = IDLE;
          end else if (w_total == '0) begin
            w_next_state = STREAM;
          end else begin
            w_next_state = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_accept) begin
          if (w_load_last) begin
            w_next_state = s_tlast ? IDLE : STREAM;
          end else if (s_tlast) begin
            w_next_state = IDLE;
          end
        end
      end
      STREAM: begin
        if (w_accept && s_tlast) w_next_state = IDLE;
      end
      DRAIN: begin
        if (w_accept && s_tlast) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ready        <= 1'b0;
      r_gap          <= 1'b0;
      r_hdr_last     <= 1'b0;
      r_load_cnt     <= '0;
      r_num_state    <= '0;
      r_num_cfg      <= '0;
      r_num_inb      <= '0;
      r_start_loader <= 1'b0;
      r_wr_data      <= '0;
      r_wr_valid     <= 1'b0;
      r_stream_data  <= '0;
      r_stream_valid <= 1'b0;
      r_err_under    <= 1'b0;
      r_err_short    <= 1'b0;
`ifdef CP_HDR_OPCODE_CHECK_EN
      r_err_opcode   <= 1'b0;
`endif
    end else begin
      r_state        <= w_next_state;
      r_ready        <= (w_next_state == IDLE) || (w_next_state == LOAD) || (w_next_state == DRAIN);
      r_start_loader <= 1'b0;
      r_wr_valid     <= 1'b0;
      r_stream_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_hdr_ok) begin
              r_num_state    <= s_tdata[dwidth_RFadd-1:0];
              r_num_cfg      <= s_tdata[2*dwidth_RFadd-1:dwidth_RFadd];
              r_num_inb      <= s_tdata[3*dwidth_RFadd-1:2*dwidth_RFadd];
              r_start_loader <= 1'b1;
              r_hdr_last     <= s_tlast;
              r_gap          <= 1'b0;
              r_load_cnt     <= '0;
            end
`ifdef CP_HDR_OPCODE_CHECK_EN
            else begin
              r_err_opcode <= 1'b1;
            end
`endif
          end
        end
        HDR_GAP: begin
          r_gap <= 1'b1;
        end
        LOAD: begin
          if (w_accept) begin
            r_wr_data  <= s_tdata;
            r_wr_valid <= 1'b1;
            r_load_cnt <= r_load_cnt + CW'(1);
            if (s_tlast && !w_load_last) r_err_short <= 1'b1;
          end else begin
            // wr_data keeps the previous beat and the count does not move.
            r_err_under <= 1'b1;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_stream_data  <= s_tdata;
            r_stream_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp_ingress_parser.sv
// tb/tb_cp_ingress_parser.sv - self-checking bench for cp_ingress_parser

module tb_cp_ingress_parser;

  localparam int PW = 512;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          start_loader;
  logic [DW-1:0] num_entry_state;
  logic [DW-1:0] num_entry_config_table;
  logic [DW-1:0] num_entry_inbound;
  logic [PW-1:0] wr_data;
  logic          wr_valid;
  logic          start_stream_in;
  logic          ready_stream_in = 1'b1;
  logic [PW-1:0] stream_data;
  logic          stream_valid;
  logic [2:0]    err;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int n_wr = 0;
  int n_st = 0;
  int n_sl = 0;
  int first_wr = 0;
  int last_wr = 0;
  int tag = 1;

  logic [PW-1:0] wr_q[$];
  logic [PW-1:0] st_q[$];

  cp_ingress_parser #(
    .phit_size(PW),
    .dwidth_RFadd(DW),
    .num_pe_tables(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .start_loader(start_loader),
    .num_entry_state(num_entry_state),
    .num_entry_config_table(num_entry_config_table),
    .num_entry_inbound(num_entry_inbound),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .start_stream_in(start_stream_in),
    .ready_stream_in(ready_stream_in),
    .stream_data(stream_data),
    .stream_valid(stream_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] beat(input int t);
    beat = {16{t}};
  endfunction

  // Advance one clock, then sample outputs and run the scoreboards.
  task automatic cyc();
    logic [PW-1:0] exp;
    @(posedge clk);
    #1;
    cyc_no++;
    if (start_loader === 1'b1) n_sl++;
    if (wr_valid === 1'b1) begin
      if (n_wr == 0) first_wr = cyc_no;
      last_wr = cyc_no;
      n_wr++;
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got wr_valid with wr_data=%h, expected no beat", wr_data[63:0]);
      end else begin
        exp = wr_q.pop_front();
        if (wr_data !== exp) begin
          errors++;
          $display("FAIL wr_data: got %h expected %h", wr_data[63:0], exp[63:0]);
        end
      end
    end
    if (stream_valid === 1'b1) begin
      n_st++;
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got stream_valid with data=%h, expected no beat", stream_data[63:0]);
      end else begin
        exp = st_q.pop_front();
        if (stream_data !== exp) begin
          errors++;
          $display("FAIL stream_data: got %h expected %h", stream_data[63:0], exp[63:0]);
        end
      end
    end
  endtask

  task automatic clear_stats();
    n_wr = 0;
    n_st = 0;
    n_sl = 0;
    first_wr = 0;
    last_wr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    ready_stream_in = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    wr_q.delete();
    st_q.delete();
    clear_stats();
  endtask

  task automatic send_header(input int st, input int cfg, input int inb, input logic [7:0] opc,
                             input logic last, output int h);
    logic [PW-1:0] d;
    d = '0;
    d[7:0] = 8'(st);
    d[15:8] = 8'(cfg);
    d[23:16] = 8'(inb);
    d[PW-1 -: 8] = opc;
    s_tdata = d;
    s_tvalid = 1'b1;
    s_tlast = last;
    h = cyc_no;
    cyc();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drive_load(input int n, input int last_idx, input int bubble_idx);
    for (int k = 0; k < n; k++) begin
      if (k == bubble_idx) begin
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        cyc();
      end
      s_tdata = beat(tag);
      tag++;
      s_tvalid = 1'b1;
      s_tlast = (k == last_idx);
      wr_q.push_back(s_tdata);
      cyc();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drive_stream(input int n, input bit toggle);
    int k;
    logic rdy;
    k = 0;
    rdy = 1'b1;
    while (k < n) begin
      ready_stream_in = rdy;
      s_tdata = beat(tag);
      s_tvalid = 1'b1;
      s_tlast = (k == n - 1);
      if (rdy) begin
        st_q.push_back(s_tdata);
        k++;
        tag++;
      end
      cyc();
      if (toggle) rdy = ~rdy;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    ready_stream_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({s_tready, start_loader, wr_valid, stream_valid, start_stream_in, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {s_tready, start_loader, wr_valid, stream_valid, start_stream_in, err});
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b expected 1", s_tready);
    end
  endtask

  task automatic test_load_and_stream();
    int h;
    clear_stats();
    send_header(2, 2, 16, 8'hA5, 1'b0, h);
    checks++;
    if ({start_loader, s_tready} !== 2'b10) begin
      errors++;
      $display("FAIL hdr_h1: got start_loader,s_tready=%b expected 10", {start_loader, s_tready});
    end
    checks++;
    if ({num_entry_state, num_entry_config_table, num_entry_inbound} !== {8'd2, 8'd2, 8'd16}) begin
      errors++;
      $display("FAIL hdr_fields: got %0d,%0d,%0d expected 2,2,16",
               num_entry_state, num_entry_config_table, num_entry_inbound);
    end
    cyc();
    checks++;
    if ({start_loader, s_tready} !== 2'b00) begin
      errors++;
      $display("FAIL hdr_h2: got start_loader,s_tready=%b expected 00", {start_loader, s_tready});
    end
    cyc();
    checks++;
    if ({s_tready, wr_valid} !== 2'b10) begin
      errors++;
      $display("FAIL load_h3: got s_tready,wr_valid=%b expected 10", {s_tready, wr_valid});
    end
    drive_load(30, -1, -1);
    checks++;
    if (n_wr != 30 || first_wr != h + 4 || last_wr != h + 33) begin
      errors++;
      $display("FAIL load_window: got n=%0d first=%0d last=%0d expected n=30 first=%0d last=%0d",
               n_wr, first_wr, last_wr, h + 4, h + 33);
    end
    checks++;
    if (start_stream_in !== 1'b1 || n_sl != 1 || err !== 3'b000) begin
      errors++;
      $display("FAIL enter_stream: got start_stream_in=%b pulses=%0d err=%b expected 1,1,000",
               start_stream_in, n_sl, err);
    end
    ready_stream_in = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL stream_ready_follow: got %b expected 0", s_tready);
    end
    ready_stream_in = 1'b1;
    for (int i = 0; i < 16; i++) st_q.push_back(beat(2));
    for (int i = 0; i < 16; i++) st_q.pop_back();
    drive_stream(16, 1'b1);
    cyc();
    checks++;
    if (n_st != 16 || st_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d beats, %0d pending expected 16, 0", n_st, st_q.size());
    end
    checks++;
    if ({start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL stream_to_idle: got start_stream_in,s_tready=%b expected 01", {start_stream_in, s_tready});
    end
  endtask

  task automatic test_underrun();
    int h;
    do_reset();
    send_header(2, 2, 16, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    drive_load(30, -1, 7);
    checks++;
    if (err !== 3'b001) begin
      errors++;
      $display("FAIL underrun_err: got %b expected 001", err);
    end
    checks++;
    if (n_wr != 30 || (last_wr - first_wr + 1) != 31 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL underrun_beats: got n=%0d span=%0d expected n=30 span=31", n_wr, last_wr - first_wr + 1);
    end
    drive_stream(2, 1'b0);
    cyc();
    checks++;
    if ({start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL underrun_idle: got %b expected 01", {start_stream_in, s_tready});
    end
  endtask

  task automatic test_short_pkt();
    int h;
    do_reset();
    send_header(2, 2, 16, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    drive_load(10, 9, -1);
    checks++;
    if (err !== 3'b010 || n_wr != 10) begin
      errors++;
      $display("FAIL short_err: got err=%b n=%0d expected 010, 10", err, n_wr);
    end
    checks++;
    if ({start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL short_idle: got %b expected 01", {start_stream_in, s_tready});
    end
    clear_stats();
    send_header(1, 0, 2, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    checks++;
    if ({num_entry_state, num_entry_config_table, num_entry_inbound} !== {8'd1, 8'd0, 8'd2} || n_sl != 1) begin
      errors++;
      $display("FAIL short_next_hdr: got %0d,%0d,%0d pulses=%0d expected 1,0,2 pulses=1",
               num_entry_state, num_entry_config_table, num_entry_inbound, n_sl);
    end
    drive_load(3, 2, -1);
    checks++;
    if (n_wr != 3 || {start_stream_in, s_tready} !== 2'b01 || err !== 3'b010) begin
      errors++;
      $display("FAIL short_next_pkt: got n=%0d state=%b err=%b expected 3, 01, 010",
               n_wr, {start_stream_in, s_tready}, err);
    end
  endtask

  task automatic test_zero_and_hdr_last();
    int h;
    do_reset();
    send_header(0, 0, 0, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    checks++;
    if ({start_stream_in, s_tready, n_sl == 1} !== 3'b111) begin
      errors++;
      $display("FAIL zero_total: got start_stream_in,s_tready,pulse=%b expected 111",
               {start_stream_in, s_tready, n_sl == 1});
    end
    drive_stream(3, 1'b0);
    cyc();
    checks++;
    if (n_st != 3 || n_wr != 0 || start_stream_in !== 1'b0) begin
      errors++;
      $display("FAIL zero_stream: got st=%0d wr=%0d ssi=%b expected 3, 0, 0", n_st, n_wr, start_stream_in);
    end
    clear_stats();
    send_header(1, 1, 1, 8'hA5, 1'b1, h);
    checks++;
    if (start_loader !== 1'b1) begin
      errors++;
      $display("FAIL hdr_last_pulse: got %b expected 1", start_loader);
    end
    cyc();
    cyc();
    checks++;
    if ({start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL hdr_last_idle: got %b expected 01", {start_stream_in, s_tready});
    end
    cyc();
    cyc();
    checks++;
    if (n_wr != 0 || n_sl != 1) begin
      errors++;
      $display("FAIL hdr_last_quiet: got wr=%0d pulses=%0d expected 0, 1", n_wr, n_sl);
    end
  endtask

  task automatic test_opcode();
    int h;
    do_reset();
    send_header(2, 2, 16, 8'h00, 1'b0, h);
`ifdef CP_HDR_OPCODE_CHECK_EN
    checks++;
    if ({start_loader, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL opcode_drain_entry: got start_loader,s_tready=%b expected 01", {start_loader, s_tready});
    end
    for (int k = 0; k < 5; k++) begin
      s_tdata = beat(tag);
      tag++;
      s_tvalid = 1'b1;
      s_tlast = (k == 4);
      cyc();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    cyc();
    checks++;
    if (err !== 3'b100 || n_sl != 0 || n_wr != 0 || n_st != 0) begin
      errors++;
      $display("FAIL opcode_bad: got err=%b pulses=%0d wr=%0d st=%0d expected 100, 0, 0, 0", err, n_sl, n_wr, n_st);
    end
    checks++;
    if ({start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL opcode_idle: got %b expected 01", {start_stream_in, s_tready});
    end
`else
    checks++;
    if (start_loader !== 1'b1) begin
      errors++;
      $display("FAIL opcode_ignored_pulse: got %b expected 1", start_loader);
    end
    cyc();
    cyc();
    drive_load(30, 29, -1);
    checks++;
    if (err !== 3'b000 || n_wr != 30 || {start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL opcode_ignored: got err=%b wr=%0d state=%b expected 000, 30, 01",
               err, n_wr, {start_stream_in, s_tready});
    end
`endif
  endtask

  task automatic test_max_count();
    int h;
    do_reset();
    send_header(255, 255, 255, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    drive_load(2040, 2039, -1);
    checks++;
    if (n_wr != 2040 || wr_q.size() != 0 || err !== 3'b000) begin
      errors++;
      $display("FAIL max_count: got wr=%0d pending=%0d err=%b expected 2040, 0, 000", n_wr, wr_q.size(), err);
    end
    checks++;
    if ({start_stream_in, s_tready} !== 2'b01) begin
      errors++;
      $display("FAIL max_count_idle: got %b expected 01", {start_stream_in, s_tready});
    end
  endtask

  task automatic test_rst_mid_load();
    int h;
    do_reset();
    send_header(2, 2, 16, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    drive_load(5, -1, -1);
    s_tdata = beat(tag);
    tag++;
    s_tvalid = 1'b1;
    rst = 1'b1;
    cyc();
    checks++;
    if ({s_tready, start_loader, wr_valid, stream_valid, start_stream_in, err} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got %b expected 00000000",
               {s_tready, start_loader, wr_valid, stream_valid, start_stream_in, err});
    end
    checks++;
    if (wr_data !== '0 || stream_data !== '0 ||
        {num_entry_state, num_entry_config_table, num_entry_inbound} !== 24'h0) begin
      errors++;
      $display("FAIL rst_mid_data: got wr=%h st=%h fields=%h expected all 0",
               wr_data[63:0], stream_data[63:0], {num_entry_state, num_entry_config_table, num_entry_inbound});
    end
    rst = 1'b0;
    s_tvalid = 1'b0;
    cyc();
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b expected 1", s_tready);
    end
    cyc();
    cyc();
    checks++;
    if (n_wr != 5 || n_sl != 1) begin
      errors++;
      $display("FAIL rst_mid_abandon: got wr=%0d pulses=%0d expected 5, 1", n_wr, n_sl);
    end
    clear_stats();
    send_header(1, 1, 1, 8'hA5, 1'b0, h);
    cyc();
    cyc();
    drive_load(8, -1, -1);
    checks++;
    if (n_wr != 8 || start_stream_in !== 1'b1) begin
      errors++;
      $display("FAIL rst_fresh_load: got wr=%0d ssi=%b expected 8, 1", n_wr, start_stream_in);
    end
    drive_stream(4, 1'b1);
    cyc();
    checks++;
    if (n_st != 4 || st_q.size() != 0 || {start_stream_in, s_tready} !== 2'b01 || err !== 3'b000) begin
      errors++;
      $display("FAIL rst_fresh_stream: got st=%0d state=%b err=%b expected 4, 01, 000",
               n_st, {start_stream_in, s_tready}, err);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_stream();
    test_underrun();
    test_short_pkt();
    test_zero_and_hdr_last();
    test_opcode();
    test_max_count();
    test_rst_mid_load();
    checks++;
    if (wr_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d wr and %0d stream pending expected 0, 0", wr_q.size(), st_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
